// File: rtl/gpu_fp_pkg.sv
// Shared constants and types for the GPU floating-point blocks.
// Covers the single-precision layout and the default adder sharing factor.
package gpu_fp_pkg;

    localparam int FP32_W      = 32;
    localparam int FP32_SIGN   = 31;
    localparam int NUM_REQ_DEF = 4;

    localparam logic [FP32_W-1:0] FP32_QNAN = 32'h7FC0_0000;

    typedef logic [$clog2(NUM_REQ_DEF)-1:0] req_id_t;

endpackage

// File: rtl/fp_add_arbiter_fl32.sv
// fl32: combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Subnormals are handled; NaN operands are returned untouched, Inf - Inf gives a quiet NaN.
module fl32
    import gpu_fp_pkg::*;
(
    input  logic [FP32_W-1:0] a,
    input  logic [FP32_W-1:0] b,
    output logic [FP32_W-1:0] y
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        a_big, sub, sign_big;
    logic [7:0]  ea, eb, el, es, diff, sh;
    logic [23:0] ml, ms;
    logic [26:0] ms_ext, ms_sh, mask, m_norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  e_norm, e_rnd;
    logic        rnd_up, hid;
    logic [24:0] m_rnd;
    logic [22:0] frac;

    // NOTE: every variable gets a default at the top of always_comb so no path leaves one unassigned (no latch).
    always_comb begin
        a_nan    = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan    = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf    = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf    = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        sub      = a[FP32_SIGN] ^ b[FP32_SIGN];
        ea       = (a[30:23] == 8'h00) ? 8'd1 : a[30:23];
        eb       = (b[30:23] == 8'h00) ? 8'd1 : b[30:23];
        a_big    = a[30:0] >= b[30:0];
        sign_big = a_big ? a[FP32_SIGN] : b[FP32_SIGN];
        el       = a_big ? ea : eb;
        es       = a_big ? eb : ea;
        ml       = a_big ? {a[30:23] != 8'h00, a[22:0]} : {b[30:23] != 8'h00, b[22:0]};
        ms       = a_big ? {b[30:23] != 8'h00, b[22:0]} : {a[30:23] != 8'h00, a[22:0]};
        diff     = el - es;
        ms_ext   = {ms, 3'b000};
        mask     = '0;

        // Align the smaller operand, folding every shifted-out bit into the sticky bit.
        if (diff >= 8'd27) begin
            ms_sh = {26'd0, |ms};
        end else begin
            mask  = (27'd1 << diff) - 27'd1;
            ms_sh = (ms_ext >> diff) | {26'd0, |(ms_ext & mask)};
        end

        sum = sub ? ({1'b0, ml, 3'b000} - {1'b0, ms_sh})
                  : ({1'b0, ml, 3'b000} + {1'b0, ms_sh});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end

        // Left shift is capped so the exponent never drops below 1 (subnormal result).
        sh = '0;
        if (sum[27]) begin
            m_norm = {sum[27:2], sum[1] | sum[0]};
            e_norm = {2'b00, el} + 10'd1;
        end else begin
            sh     = ({3'b000, lz} > (el - 8'd1)) ? (el - 8'd1) : {3'b000, lz};
            m_norm = sum[26:0] << sh;
            e_norm = {2'b00, el} - {2'b00, sh};
        end

        rnd_up = m_norm[2] & (m_norm[3] | m_norm[1] | m_norm[0]);
        m_rnd  = {1'b0, m_norm[26:3]} + {24'd0, rnd_up};
        e_rnd  = m_rnd[24] ? e_norm + 10'd1 : e_norm;
        frac   = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
        hid    = m_rnd[24] | m_rnd[23];

        if (e_rnd >= 10'd255) y = {sign_big, 8'hFF, 23'd0};
        else                  y = {sign_big, hid ? e_rnd[7:0] : 8'h00, frac};

        if (sum == 28'd0) y = {sub ? 1'b0 : a[FP32_SIGN], 31'd0};

        if (a_nan)                        y = a;
        else if (b_nan)                   y = b;
        else if (a_inf && b_inf && sub)   y = FP32_QNAN;
        else if (a_inf)                   y = a;
        else if (b_inf)                   y = b;
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter: round-robin sharing of one fl32 adder between NUM_REQ requesters.
// Two-stage pipeline: S1 holds operands, S2 holds the result presented to the consumer.
module fp_add_arbiter
    import gpu_fp_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][FP32_W-1:0]   req_a,
    input  logic [NUM_REQ-1:0][FP32_W-1:0]   req_b,
    input  logic [NUM_REQ-1:0]               req_sub,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [ID_W-1:0]                  res_id,
    output logic [FP32_W-1:0]                res_data,
    output logic [CNT_W-1:0]                 op_count
);

    logic              s1_valid, s2_valid;
    logic [ID_W-1:0]   s1_id;
    logic [FP32_W-1:0] s1_a, s1_b, b_mod, fl_y;
    logic [ID_W-1:0]   rr_ptr, win, rr_next;
    logic              found, grant, s2_adv, s1_accept;

    assign s2_adv    = !s2_valid || res_ready;
    assign s1_accept = !s1_valid || s2_adv;
    assign res_valid = s2_valid;

    // First valid requester at or above rr_ptr, wrapping to 0.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    assign grant   = found && s1_accept && !rst;
    assign rr_next = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;

    always_comb begin
        req_ready = '0;
        if (grant) req_ready[win] = 1'b1;
        b_mod = req_b[win];
        b_mod[FP32_SIGN] = req_b[win][FP32_SIGN] ^ req_sub[win];
    end

    fl32 u_fl32 (
        .a (s1_a),
        .b (s1_b),
        .y (fl_y)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            rr_ptr   <= '0;
            op_count <= '0;
        end else begin
            if (s1_accept) s1_valid <= grant;
            if (s2_adv)    s2_valid <= s1_valid;
            if (grant) begin
                rr_ptr   <= rr_next;
                op_count <= op_count + 1'b1;
            end
        end
    end

    // NOTE: payload registers carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge clk) begin
        if (grant) begin
            s1_id <= win;
            s1_a  <= req_a[win];
            s1_b  <= b_mod;
        end
        if (s2_adv && s1_valid) begin
            res_id   <= s1_id;
            res_data <= fl_y;
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed self-checking bench for fp_add_arbiter: latency, round-robin order,
// backpressure, reset mid-flight, special operands and op_count wrap.
module tb_fp_add_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       req_valid, req_ready, req_sub;
    logic [3:0][31:0] req_a, req_b;
    logic             res_valid, res_ready;
    logic [1:0]       res_id;
    logic [31:0]      res_data;
    logic [15:0]      op_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_add_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .op_count  (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0]  rr_ids  [5];
        logic [31:0] rr_data [5];
        logic [3:0]  pending, exp_ready;
        int          accepted;

        rr_ids  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rr_data = '{32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 32'h40A0_0000, 32'h4000_0000};

        rst = 1'b1; req_valid = 4'hF; req_sub = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
        step(); step();
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_count", {16'd0, op_count}, 32'd0);
        req_valid = '0; rst = 1'b0;
        step();

        // 1.0 + 2.0 from requester 0
        req_a[0] = 32'h3F80_0000; req_b[0] = 32'h4000_0000; req_valid = 4'b0001; #1;
        check("add_ready", {28'd0, req_ready}, 32'h1);
        step(); req_valid = '0;
        check("add_lat1", {31'd0, res_valid}, 32'd0);
        step();
        check("add_valid", {31'd0, res_valid}, 32'd1);
        check("add_id", {30'd0, res_id}, 32'd0);
        check("add_data", res_data, 32'h4040_0000);
        check("add_count", {16'd0, op_count}, 32'd1);
        step();
        check("add_drained", {31'd0, res_valid}, 32'd0);

        // 3.0 - 1.0 from requester 2
        req_a[2] = 32'h4040_0000; req_b[2] = 32'h3F80_0000; req_sub = 4'b0100; req_valid = 4'b0100; #1;
        check("sub_ready", {28'd0, req_ready}, 32'h4);
        step(); req_valid = '0; req_sub = '0;
        step();
        check("sub_id", {30'd0, res_id}, 32'd2);
        check("sub_data", res_data, 32'h4000_0000);
        step();

        // Round robin with all four requesters valid, starting from pointer 0
        rst = 1'b1; step(); rst = 1'b0;
        check("rr_rst_count", {16'd0, op_count}, 32'd0);
        req_a[0] = 32'h3F80_0000; req_a[1] = 32'h4000_0000;
        req_a[2] = 32'h4040_0000; req_a[3] = 32'h4080_0000;
        req_b    = {4{32'h3F80_0000}};
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 5) ? 4'hF : 4'h0; #1;
            check($sformatf("rr_ready_%0d", c), {28'd0, req_ready},
                  (c < 5) ? (32'd1 << rr_ids[c]) : 32'd0);
            if (c >= 2) begin
                check($sformatf("rr_valid_%0d", c), {31'd0, res_valid}, 32'd1);
                check($sformatf("rr_id_%0d", c), {30'd0, res_id}, {30'd0, rr_ids[c-2]});
                check($sformatf("rr_data_%0d", c), res_data, rr_data[c-2]);
            end
            step();
        end
        check("rr_count", {16'd0, op_count}, 32'd5);

        // Backpressure: three pending, consumer stalled for five cycles
        req_a[1] = 32'h3F80_0000; req_b[1] = 32'h3F80_0000;
        req_a[2] = 32'h4000_0000; req_b[2] = 32'h4000_0000;
        req_a[3] = 32'h4080_0000; req_b[3] = 32'h3F80_0000; req_sub = 4'b1000;
        pending = 4'b1110; res_ready = 1'b0; accepted = 0;
        for (int c = 0; c < 5; c++) begin
            req_valid = pending; #1;
            exp_ready = (c == 0) ? 4'b0010 : (c == 1) ? 4'b0100 : 4'b0000;
            check($sformatf("bp_ready_%0d", c), {28'd0, req_ready}, {28'd0, exp_ready});
            accepted += $countones(req_ready & req_valid);
            if (c >= 2) begin
                check($sformatf("bp_hold_id_%0d", c), {30'd0, res_id}, 32'd1);
                check($sformatf("bp_hold_data_%0d", c), res_data, 32'h4000_0000);
            end
            step();
            pending = pending & ~exp_ready;
        end
        check("bp_accepted", accepted, 32'd2);
        res_ready = 1'b1; req_valid = pending; #1;
        check("bp_resume_ready", {28'd0, req_ready}, 32'h8);
        check("bp_out1_id", {30'd0, res_id}, 32'd1);
        step(); req_valid = '0; req_sub = '0;
        check("bp_out2_id", {30'd0, res_id}, 32'd2);
        check("bp_out2_data", res_data, 32'h4080_0000);
        step();
        check("bp_out3_id", {30'd0, res_id}, 32'd3);
        check("bp_out3_data", res_data, 32'h4040_0000);
        step();
        check("bp_empty", {31'd0, res_valid}, 32'd0);
        check("bp_count", {16'd0, op_count}, 32'd8);

        // Fill S1 and S2, then reset
        res_ready = 1'b0; req_valid = 4'b0110; #1;
        check("fill_ready1", {28'd0, req_ready}, 32'h2);
        step(); req_valid = 4'b0100; #1;
        check("fill_ready2", {28'd0, req_ready}, 32'h4);
        step(); req_valid = '0;
        check("fill_valid", {31'd0, res_valid}, 32'd1);
        rst = 1'b1; req_valid = 4'hF; #1;
        check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
        step(); rst = 1'b0; #1;
        check("post_rst_valid", {31'd0, res_valid}, 32'd0);
        check("post_rst_count", {16'd0, op_count}, 32'd0);
        check("post_rst_grant", {28'd0, req_ready}, 32'h1);
        req_valid = '0; res_ready = 1'b1;
        step(); step();
        check("no_ghost", {31'd0, res_valid}, 32'd0);

        // +Inf + 1.0 stays +Inf
        req_a[0] = 32'h7F80_0000; req_b[0] = 32'h3F80_0000; req_valid = 4'b0001; #1;
        check("inf_ready", {28'd0, req_ready}, 32'h1);
        step(); req_valid = '0;
        step();
        check("inf_data", res_data, 32'h7F80_0000);
        step();

        // op_count wrap after 2^16 accepts
        rst = 1'b1; step(); rst = 1'b0; req_valid = 4'hF;
        repeat (65535) @(posedge clk);
        #1;
        check("cnt_max", {16'd0, op_count}, 32'h0000_FFFF);
        step();
        check("cnt_wrap", {16'd0, op_count}, 32'd0);
        req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one fl32 adder.
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the issued-operation counter.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: per-requester operation valid.
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept; at most one bit is high per cycle.
REQ-008 SHALL have port req_a, input, NUM_REQ x 32 bits: operand A per requester, IEEE-754 single.
REQ-009 SHALL have port req_b, input, NUM_REQ x 32 bits: operand B per requester, IEEE-754 single.
REQ-010 SHALL have port req_sub, input, NUM_REQ bits: 1 means compute A minus B.
REQ-011 SHALL have port res_valid, output, 1 bit: result valid.
REQ-012 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port res_id, output, clog2(NUM_REQ) bits: index of the requester that owns the result.
REQ-014 SHALL have port res_data, output, 32 bits: sum or difference.
REQ-015 SHALL have port op_count, output, CNT_W bits: number of operations accepted since reset.

Function
REQ-016 SHALL use a two-stage pipeline: S1 is the operand register (valid, id, a, b'); S2 is the result register (valid, id, data), loaded from the fl32 output driven by S1.
REQ-017 SHALL form b' as req_b with bit 31 inverted when req_sub=1, and as req_b unchanged otherwise; no other operand modification.
REQ-018 S2 SHALL advance when !s2_valid or res_ready.
REQ-019 S1 SHALL accept a new operation when !s1_valid or S2 advances.
REQ-020 A transfer SHALL occur only when req_valid[i] and req_ready[i] are both high in the same cycle.
REQ-021 req_ready[i] SHALL be high only when S1 can accept, req_valid[i]=1, and i is the round-robin winner; req_ready SHALL depend combinationally on req_valid and res_ready.
REQ-022 Round-robin: search SHALL start at pointer rr_ptr and proceed upward, wrapping from NUM_REQ-1 to 0.
REQ-023 After a grant to i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-024 Latency SHALL be 2: an operation accepted at edge N presents res_valid at edge N+1 output register... specifically, res_valid SHALL be visible in the cycle after edge N+1 when unstalled; throughput SHALL be 1 operation per cycle.
REQ-025 While res_valid=1 and res_ready=0, res_id and res_data SHALL hold stable; S1 SHALL hold; no grant SHALL occur if S1 is full.
REQ-026 Results SHALL retire in acceptance order; none SHALL be dropped or duplicated.
REQ-027 op_count SHALL increment by 1 per accepted operation and wrap from 2^CNT_W-1 to 0.
REQ-028 Special operands (Inf, NaN) SHALL pass through fl32 unaltered; the arbiter SHALL NOT inspect them.
REQ-029 A requester SHALL keep req_a, req_b and req_sub stable until accepted; the block SHALL NOT rely on operand stability after acceptance.

Reset
REQ-030 While rst=1, the block SHALL clear s1_valid and s2_valid, drive res_valid=0, hold all req_ready=0, set rr_ptr=0 and set op_count=0.
REQ-031 Reset asserted mid-operation SHALL discard in-flight S1/S2 contents; no result SHALL emerge after reset.
REQ-032 The data registers (S1 operands, res_data, res_id) SHALL need no reset.

Structure
REQ-033 Package gpu_fp_pkg SHALL hold FP32_W=32, the sign-bit index 31, the default NUM_REQ, and the requester id typedef.
REQ-034 The block SHALL instantiate exactly one fl32 as its sub-module, between S1 and S2; the round-robin logic SHALL stay inline.

Verification
REQ-035 Single op: req 0 with a=0x3F800000, b=0x40000000, sub=0 -> res_valid after 2 cycles with res_id=0 and res_data=0x40400000 (3.0).
REQ-036 Subtract: req 2 with a=0x40400000, b=0x3F800000, sub=1 -> res_data=0x40000000 (2.0) and res_id=2.
REQ-037 All 4 requesters valid continuously with res_ready=1 -> grants go 0,1,2,3,0 on consecutive cycles, results arrive in the same order, and op_count=5.
REQ-038 Backpressure: res_ready=0 for 5 cycles with 3 requests pending -> exactly 2 operations are accepted, res_data holds, and no loss occurs after res_ready=1.
REQ-039 Reset asserted with S1 and S2 full -> next cycle res_valid=0, op_count=0, and the next grant goes to requester 0.
REQ-040 op_count preloaded by 2^16 accepts -> op_count wraps to 0.
